// File: rtl/red_pitaya_relock_block_if.sv
// Relock block bus: limiter-side data, sweep configuration, lock detect and
// the actuator/status outputs, grouped so the channel wiring stays compact.
interface red_pitaya_relock_block_if #(
    parameter int CNT_W  = 32,
    parameter int UCNT_W = 16
);
    logic                     enable_i;
    logic signed [13:0]       signal_i;
    logic        [1:0]        railed_i;
    logic signed [13:0]       min_val_i;
    logic signed [13:0]       max_val_i;
    logic        [CNT_W-1:0]  hold_cycles_i;
    logic        [13:0]       sweep_step_i;
    logic                     lock_i;
    logic signed [13:0]       signal_o;
    logic                     pid_hold_o;
    logic        [1:0]        state_o;
    logic        [UCNT_W-1:0] unlock_cnt_o;

    // driver side (channel wiring / bench)
    modport master (
        output enable_i, signal_i, railed_i, min_val_i, max_val_i,
               hold_cycles_i, sweep_step_i, lock_i,
        input  signal_o, pid_hold_o, state_o, unlock_cnt_o
    );

    // relock block side
    modport slave (
        input  enable_i, signal_i, railed_i, min_val_i, max_val_i,
               hold_cycles_i, sweep_step_i, lock_i,
        output signal_o, pid_hold_o, state_o, unlock_cnt_o
    );
endinterface

// File: rtl/red_pitaya_relock_block.sv
// Rail monitor and relock sweeper, downstream of the limiter.
// Optional feature macro: RELOCK_UNLOCK_COUNT_EN -- when defined, unlock_cnt_o
// is a saturating count of entries into SWEEP; otherwise it is tied to 0.
module red_pitaya_relock_block #(
    parameter int CNT_W  = 32,
    parameter int UCNT_W = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    red_pitaya_relock_block_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCKED = 2'd1,
        RAILED = 2'd2,
        SWEEP  = 2'd3
    } state_t;

    state_t             state_q, state_nxt;
    logic [CNT_W-1:0]   cnt_q, cnt_nxt;
    logic signed [13:0] acc_q, acc_nxt;
    logic               dir_dn_q, dir_dn_nxt;
    logic signed [13:0] sig_q, sig_nxt;

    // effective hold: 0 behaves like 1; rail counter increments saturate
    logic [CNT_W-1:0] hold_eff, cnt_inc;
    assign hold_eff = (bus.hold_cycles_i == '0) ? CNT_W'(1) : bus.hold_cycles_i;
    assign cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

    // sweep arithmetic in 16-bit signed so acc +/- step cannot wrap
    logic signed [15:0] acc16, step16, min16, max16, nxt_raw;
    logic signed [13:0] sweep_val;
    logic               sweep_dn;
    assign acc16   = 16'(acc_q);
    assign step16  = {2'b00, bus.sweep_step_i};
    assign min16   = 16'(bus.min_val_i);
    assign max16   = 16'(bus.max_val_i);
    assign nxt_raw = dir_dn_q ? (acc16 - step16) : (acc16 + step16);

    // next sweep point: degenerate bounds pin to min, otherwise clamp and reverse
    always_comb begin
        sweep_val = nxt_raw[13:0];
        sweep_dn  = dir_dn_q;
        if (min16 >= max16) begin
            sweep_val = bus.min_val_i;
        end else if (nxt_raw >= max16) begin
            sweep_val = bus.max_val_i;
            sweep_dn  = 1'b1;
        end else if (nxt_raw <= min16) begin
            sweep_val = bus.min_val_i;
            sweep_dn  = 1'b0;
        end
    end

    // next-state and datapath: disable wins, lock wins over bound reversal
    always_comb begin
        state_nxt  = state_q;
        cnt_nxt    = cnt_q;
        acc_nxt    = acc_q;
        dir_dn_nxt = dir_dn_q;
        sig_nxt    = bus.signal_i;
        if (!bus.enable_i) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state_q)
                IDLE: state_nxt = LOCKED;
                LOCKED: begin
                    if (bus.railed_i != 2'b00) begin
                        if (hold_eff <= CNT_W'(1)) begin
                            state_nxt = SWEEP;
                            cnt_nxt   = '0;
                        end else begin
                            state_nxt = RAILED;
                            cnt_nxt   = CNT_W'(1);
                        end
                    end
                end
                RAILED: begin
                    if (bus.railed_i == 2'b00) begin
                        state_nxt = LOCKED;
                        cnt_nxt   = '0;
                    end else if (cnt_inc >= hold_eff) begin
                        state_nxt = SWEEP;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end
                SWEEP: begin
                    if (bus.lock_i) begin
                        state_nxt = LOCKED;
                    end else begin
                        acc_nxt    = sweep_val;
                        dir_dn_nxt = sweep_dn;
                        sig_nxt    = sweep_val;
                    end
                end
                default: state_nxt = IDLE;
            endcase
            // seed the sweep from the railed sample, heading away from the rail hit
            if (state_q != SWEEP && state_nxt == SWEEP) begin
                acc_nxt    = bus.signal_i;
                dir_dn_nxt = bus.railed_i[1];
            end
        end
    end

    // state and datapath registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            dir_dn_q <= 1'b0;
            sig_q    <= '0;
        end else begin
            state_q  <= state_nxt;
            cnt_q    <= cnt_nxt;
            acc_q    <= acc_nxt;
            dir_dn_q <= dir_dn_nxt;
            sig_q    <= sig_nxt;
        end
    end

    assign bus.signal_o   = sig_q;
    assign bus.state_o    = state_q;
    assign bus.pid_hold_o = (state_q == SWEEP);

`ifdef RELOCK_UNLOCK_COUNT_EN
    logic [UCNT_W-1:0] ucnt_q;
    logic              unlock_inc;
    assign unlock_inc = bus.enable_i && (state_q != SWEEP) && (state_nxt == SWEEP);

    // saturating unlock event counter, survives disable
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            ucnt_q <= '0;
        else if (unlock_inc && !(&ucnt_q))
            ucnt_q <= ucnt_q + UCNT_W'(1);
    end
    assign bus.unlock_cnt_o = ucnt_q;
`else
    assign bus.unlock_cnt_o = '0;
`endif
endmodule

// File: tb/tb_red_pitaya_relock_block.sv
// Directed bench for red_pitaya_relock_block with an expected-value queue.
module tb_red_pitaya_relock_block;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    red_pitaya_relock_block_if #(.CNT_W(32), .UCNT_W(16)) bus ();

    red_pitaya_relock_block #(.CNT_W(32), .UCNT_W(16)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

`ifdef RELOCK_UNLOCK_COUNT_EN
    localparam int U_ON = 1;
`else
    localparam int U_ON = 0;
`endif

    typedef struct {
        int    sig;
        int    st;
        int    hold;
        int    ucnt;
        string tag;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // drive one sample, queue what must appear after the next edge, then check it
    task automatic step(input logic en, input int sig, input logic [1:0] rail,
                        input logic lk, input int es, input int est,
                        input int eh, input int eu, input string tag);
        exp_t e;
        bus.enable_i = en;
        bus.signal_i = 14'(sig);
        bus.railed_i = rail;
        bus.lock_i   = lk;
        q.push_back('{es, est, eh, eu, tag});
        @(posedge clk);
        #1;
        e = q.pop_front();
        chk({e.tag, ".sig"},   bus.signal_o,           e.sig);
        chk({e.tag, ".state"}, {30'd0, bus.state_o},   e.st);
        chk({e.tag, ".hold"},  {31'd0, bus.pid_hold_o}, e.hold);
        chk({e.tag, ".ucnt"},  {16'd0, bus.unlock_cnt_o}, e.ucnt);
    endtask

    initial begin
        bus.enable_i      = 1'b0;
        bus.signal_i      = '0;
        bus.railed_i      = 2'b00;
        bus.min_val_i     = -14'sd8000;
        bus.max_val_i     = 14'sd8000;
        bus.hold_cycles_i = 32'd10;
        bus.sweep_step_i  = 14'd1000;
        bus.lock_i        = 1'b0;

        #12;
        chk("rst.sig",   bus.signal_o, 0);
        chk("rst.state", {30'd0, bus.state_o}, 0);
        chk("rst.hold",  {31'd0, bus.pid_hold_o}, 0);
        chk("rst.ucnt",  {16'd0, bus.unlock_cnt_o}, 0);
        @(negedge clk);
        rst = 1'b0;

        // pass-through while disabled
        step(0, 1234, 2'b00, 0, 1234, 0, 0, 0, "bypass");
        step(1, 100,  2'b00, 0, 100,  1, 0, 0, "enable");

        // short rail: 9 railed samples with hold 10 never unlocks
        for (int i = 0; i < 9; i++)
            step(1, 8000, 2'b10, 0, 8000, 2, 0, 0, "short_rail");
        step(1, 200, 2'b00, 0, 200, 1, 0, 0, "short_rel");

        // upper-rail unlock with hold 4, then downward sweep
        bus.hold_cycles_i = 32'd4;
        for (int i = 0; i < 3; i++)
            step(1, 8000, 2'b10, 0, 8000, 2, 0, 0, "up_railed");
        step(1, 8000, 2'b10, 0, 8000, 3, 1, U_ON, "unlock");
        for (int i = 1; i <= 14; i++)
            step(1, 8000, 2'b10, 0, 8000 - 1000 * i, 3, 1, U_ON, "sweep_dn");

        // bound reversal at min: -6000 - 3000 clamps to -8000, then climbs
        bus.sweep_step_i = 14'd3000;
        step(1, 8000, 2'b00, 0, -8000, 3, 1, U_ON, "clamp_min");
        step(1, 8000, 2'b00, 0, -5000, 3, 1, U_ON, "reverse");

        // relock: lock wins, pass-through resumes on the same edge
        step(1, 50, 2'b00, 1, 50, 1, 0, U_ON, "relock");
        step(1, 60, 2'b00, 0, 60, 1, 0, U_ON, "locked");

        // hold 0 acts like 1: lower rail unlocks immediately, sweeps up
        bus.hold_cycles_i = 32'd0;
        bus.sweep_step_i  = 14'd1000;
        step(1, -8000, 2'b01, 0, -8000, 3, 1, 2 * U_ON, "hold0_unlock");
        step(1, -8000, 2'b01, 0, -7000, 3, 1, 2 * U_ON, "sweep_up");

        // degenerate bounds pin the output to min
        bus.min_val_i = 14'sd500;
        bus.max_val_i = -14'sd500;
        step(1, 0, 2'b00, 0, 500, 3, 1, 2 * U_ON, "degenerate");
        bus.min_val_i = -14'sd8000;
        bus.max_val_i = 14'sd8000;

        // zero step holds the accumulator
        bus.sweep_step_i = 14'd0;
        step(1, 0, 2'b00, 0, 500, 3, 1, 2 * U_ON, "step0");

        // asynchronous reset between edges
        #3;
        rst = 1'b1;
        #1;
        chk("arst.sig",   bus.signal_o, 0);
        chk("arst.state", {30'd0, bus.state_o}, 0);
        chk("arst.hold",  {31'd0, bus.pid_hold_o}, 0);
        chk("arst.ucnt",  {16'd0, bus.unlock_cnt_o}, 0);
        chk("sb.empty",   q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
